// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Valid/ready on both sides; an opaque tag travels with each operation.
module div_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [XLEN-1:0]  in_op1,
   input  logic [XLEN-1:0]  in_op2,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state_q;
   logic             sel_rem_q;
   logic             qneg_q;
   logic             rneg_q;
   logic [TAG_W-1:0] tag_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             out_valid_q;
   logic [XLEN-1:0]  out_result_q;
   logic [TAG_W-1:0] out_tag_q;

   logic             signed_op;
   logic [XLEN-1:0]  int_min;
   logic [XLEN-1:0]  abs1;
   logic [XLEN-1:0]  abs2;
   logic             div_zero;
   logic             overflow;
   logic [XLEN-1:0]  special_res;
   logic [XLEN:0]    rem_shift;
   logic [XLEN:0]    rem_sub;
   logic             rem_ge;
   logic [XLEN-1:0]  rem_d;
   logic [XLEN-1:0]  quo_d;
   logic [XLEN-1:0]  quo_fix;
   logic [XLEN-1:0]  rem_fix;
   logic [XLEN-1:0]  result_d;

   always_comb begin
      signed_op   = ~in_op[0];
      int_min     = '0;
      int_min[XLEN-1] = 1'b1;
      abs1        = (signed_op && in_op1[XLEN-1]) ? -in_op1 : in_op1;
      abs2        = (signed_op && in_op2[XLEN-1]) ? -in_op2 : in_op2;
      div_zero    = (in_op2 == '0);
      overflow    = signed_op && (in_op1 == int_min) && (in_op2 == '1);
      special_res = '0;
      if (div_zero)
         special_res = in_op[1] ? in_op1 : '1;
      else if (overflow)
         special_res = in_op[1] ? '0 : int_min;
   end

   // One restoring step: the shifted partial remainder needs XLEN+1 bits.
   always_comb begin
      rem_shift = {rem_q, quo_q[XLEN-1]};
      rem_sub   = rem_shift - {1'b0, dvs_q};
      rem_ge    = (rem_shift >= {1'b0, dvs_q});
      rem_d     = rem_ge ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
      quo_d     = {quo_q[XLEN-2:0], rem_ge};
      quo_fix   = qneg_q ? -quo_q : quo_q;
      rem_fix   = rneg_q ? -rem_q : rem_q;
      result_d  = sel_rem_q ? rem_fix : quo_fix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_rem_q    <= 1'b0;
         qneg_q       <= 1'b0;
         rneg_q       <= 1'b0;
         tag_q        <= '0;
         quo_q        <= '0;
         rem_q        <= '0;
         dvs_q        <= '0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
      end else if (flush) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sel_rem_q <= in_op[1];
                  tag_q     <= in_tag;
                  if (div_zero || overflow) begin
                     out_result_q <= special_res;
                     out_tag_q    <= in_tag;
                     out_valid_q  <= 1'b1;
                     state_q      <= DONE;
                  end else begin
                     quo_q   <= abs1;
                     dvs_q   <= abs2;
                     rem_q   <= '0;
                     cnt_q   <= '0;
                     qneg_q  <= signed_op && (in_op1[XLEN-1] ^ in_op2[XLEN-1]);
                     rneg_q  <= signed_op && in_op1[XLEN-1];
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(XLEN - 1))
                  state_q <= FIX;
            end
            FIX: begin
               out_result_q <= result_d;
               out_tag_q    <= tag_q;
               out_valid_q  <= 1'b1;
               state_q      <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, checked on out_valid.
module tb_div_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_op1;
   logic [31:0] in_op2;
   logic [4:0]  in_tag;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        busy;

   int n_checks;
   int n_fail;

   logic [31:0] exp_res_q[$];
   logic [4:0]  exp_tag_q[$];
   int          exp_lat_q[$];

   div_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'b00:   return sa / sb;
         2'b01:   return a / b;
         2'b10:   return sa % sb;
         default: return a % b;
      endcase
   endfunction

   // Latency = rising edges after the accepting edge until out_valid is seen.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold);
      int k;
      logic [31:0] er;
      logic [4:0]  et;
      int          el;
      logic [31:0] held_res;
      logic [4:0]  held_tag;
      exp_res_q.push_back(model(op, a, b));
      exp_tag_q.push_back(tag);
      exp_lat_q.push_back((b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 33);
      k = 0;
      while (!in_ready && k < 100) begin @(negedge clk); k++; end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_tag = tag;
      @(negedge clk);
      in_valid = 1'b0; in_op = 2'($urandom); in_op1 = $urandom; in_op2 = $urandom; in_tag = 5'($urandom);
      k = 1;
      while (!out_valid && k < 100) begin @(negedge clk); k++; end
      er = exp_res_q.pop_front();
      et = exp_tag_q.pop_front();
      el = exp_lat_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || (k - 1) !== el) begin
         n_fail++;
         $display("FAIL latency op=%0d a=%h b=%h: out_valid=%b after %0d edges, required 1 after %0d",
                  op, a, b, out_valid, k - 1, el);
      end
      n_checks++;
      if (out_result !== er) begin
         n_fail++;
         $display("FAIL result op=%0d a=%h b=%h: got %h required %h", op, a, b, out_result, er);
      end
      n_checks++;
      if (out_tag !== et) begin
         n_fail++;
         $display("FAIL tag op=%0d: got %h required %h", op, out_tag, et);
      end
      held_res = out_result;
      held_tag = out_tag;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; in_op1 = $urandom; in_op2 = $urandom; in_tag = 5'($urandom);
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || out_result !== held_res || out_tag !== held_tag || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold cycle %0d: valid=%b res=%h tag=%h ready=%b required 1 %h %h 0",
                     h, out_valid, out_result, out_tag, in_ready, held_res, held_tag);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL release: valid=%b ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: valid=%b res=%h tag=%h busy=%b ready=%b required 0 0 0 0 1",
                  name, out_valid, out_result, out_tag, busy, in_ready);
      end
   endtask

   task automatic check_quiet(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL %s: out_valid high %0d cycles, required 0", name, seen);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("after_reset");
   endtask

   task automatic test_unsigned();
      do_op(2'b01, 32'd100, 32'd7, 5'd1, 0);
      do_op(2'b11, 32'd100, 32'd7, 5'd2, 0);
      do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd3, 0);
      do_op(2'b11, 32'd5, 32'd9, 5'd4, 0);
   endtask

   task automatic test_signed();
      do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
      do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd7, 0);
      do_op(2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 5'd8, 0);
   endtask

   task automatic test_div_zero();
      do_op(2'b00, 32'd5, 32'd0, 5'd9, 0);
      do_op(2'b01, 32'd5, 32'd0, 5'd10, 0);
      do_op(2'b11, 32'd5, 32'd0, 5'd11, 0);
      do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd12, 0);
   endtask

   task automatic test_overflow();
      do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
      do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
   endtask

   task automatic test_backpressure();
      do_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd16, 10);
      do_op(2'b11, 32'd9, 32'd0, 5'd17, 10);
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_op = 2'b01; in_op1 = 32'd12345; in_op2 = 32'd7; in_tag = 5'd18;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_calc: busy=%b ready=%b valid=%b required 0 1 0", busy, in_ready, out_valid);
      end
      check_quiet("flush_no_result", 40);
      in_valid = 1'b1; in_op = 2'b01; in_op1 = 32'd8; in_op2 = 32'd0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_priority: busy=%b valid=%b required 0 0", busy, out_valid);
      end
      do_op(2'b01, 32'hFFFF_FFFF, 32'd3, 5'd19, 0);
   endtask

   task automatic test_reset_mid_calc();
      in_valid = 1'b1; in_op = 2'b00; in_op1 = 32'hFFFF_0000; in_op2 = 32'd77; in_tag = 5'd20;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_calc");
      @(negedge clk);
      rst_n = 1'b1;
      check_quiet("reset_no_result", 40);
      do_op(2'b11, 32'd1000, 32'd33, 5'd21, 0);
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 12; i++) begin
         op = 2'($urandom);
         a  = $urandom;
         case (i % 4)
            0: b = $urandom;
            1: b = 32'($urandom_range(1, 15));
            2: b = -32'($urandom_range(1, 15));
            default: b = (i == 7) ? 32'd0 : $urandom >> $urandom_range(0, 31);
         endcase
         do_op(op, a, b, 5'(i + 22), 0);
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      in_valid = 1'b0; in_op = 2'b00; in_op1 = '0; in_op2 = '0; in_tag = '0;
      flush = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_backpressure();
      test_flush();
      test_reset_mid_calc();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
